// File: rtl/reg_file_2w2r.sv
// Parametrised 2-write / 2-read register file with fixed write priority,
// optional write-to-read bypass and a per-register pending-write scoreboard.
module reg_file_2w2r #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 3,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [ADDR_W-1:0]      rd_addr_a,
    input  logic [ADDR_W-1:0]      rd_addr_b,
    output logic [DATA_W-1:0]      rd_data_a,
    output logic [DATA_W-1:0]      rd_data_b,
    input  logic                   we0,
    input  logic [ADDR_W-1:0]      wr_addr0,
    input  logic [DATA_W-1:0]      wr_data0,
    input  logic                   we1,
    input  logic [ADDR_W-1:0]      wr_addr1,
    input  logic [DATA_W-1:0]      wr_data1,
    input  logic                   busy_set,
    input  logic [ADDR_W-1:0]      busy_addr,
    output logic                   busy_a,
    output logic                   busy_b,
    output logic [2**ADDR_W-1:0]   busy_vec,
    output logic                   wr_conflict
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_d;
    logic              conflict_q;
    logic              conflict_d;

    // A write or busy_set aimed at a hard-wired zero register is dropped here.
    logic wr0_ok;
    logic wr1_ok;
    logic busy_set_ok;

    assign wr0_ok      = we0      && !((ZERO_REG != 0) && (wr_addr0  == '0));
    assign wr1_ok      = we1      && !((ZERO_REG != 0) && (wr_addr1  == '0));
    assign busy_set_ok = busy_set && !((ZERO_REG != 0) && (busy_addr == '0));

    always_comb begin
        regs_d     = regs_q;
        busy_d     = busy_q;
        conflict_d = 1'b0;
        // NOTE: port 1 is applied before port 0 so that, with blocking
        // assignments, port 0 overwrites it on an address collision.
        if (wr1_ok) begin
            regs_d[wr_addr1] = wr_data1;
            busy_d[wr_addr1] = 1'b0;
        end
        if (wr0_ok) begin
            regs_d[wr_addr0] = wr_data0;
            busy_d[wr_addr0] = 1'b0;
        end
        // Applied last: a new pending write outlives a completing older one.
        if (busy_set_ok) begin
            busy_d[busy_addr] = 1'b1;
        end
        if (wr0_ok && wr1_ok && (wr_addr0 == wr_addr1)) begin
            conflict_d = 1'b1;
        end
    end

    // NOTE: storage is built from flops, not a RAM macro, so every entry can
    // be cleared by the asynchronous reset like any other state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            busy_q     <= '0;
            conflict_q <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= regs_d[i];
            end
            busy_q     <= busy_d;
            conflict_q <= conflict_d;
        end
    end

    function automatic logic [DATA_W-1:0] read_mux(input logic [ADDR_W-1:0] addr);
        if ((ZERO_REG != 0) && (addr == '0)) begin
            return '0;
        end
        if ((BYPASS != 0) && we0 && (wr_addr0 == addr)) begin
            return wr_data0;
        end
        if ((BYPASS != 0) && we1 && (wr_addr1 == addr)) begin
            return wr_data1;
        end
        return regs_q[addr];
    endfunction

    // A forwarded value needs no stall, so bypass hides the busy bit.
    function automatic logic busy_lookup(input logic [ADDR_W-1:0] addr);
        if ((BYPASS != 0) && ((we0 && (wr_addr0 == addr)) || (we1 && (wr_addr1 == addr)))) begin
            return 1'b0;
        end
        return busy_q[addr];
    endfunction

    assign rd_data_a   = read_mux(rd_addr_a);
    assign rd_data_b   = read_mux(rd_addr_b);
    assign busy_a      = busy_lookup(rd_addr_a);
    assign busy_b      = busy_lookup(rd_addr_b);
    assign busy_vec    = busy_q;
    assign wr_conflict = conflict_q;

endmodule

// File: doc/reg_file_2w2r.md
Name: reg_file_2w2r

Overview:
Parametrised general-purpose register file for the MCU datapath. It has two combinational read ports, two write ports with fixed priority, and optional write-to-read bypass. A per-register busy scoreboard lets the issue logic stall on pending writebacks. It replaces the fixed 8x8, single-write register file and sits between decode (read and issue) and writeback (write).

Parameters:
DATA_W, 8, width of each register in bits
ADDR_W, 3, address width; depth is 2**ADDR_W registers
ZERO_REG, 1, 1 = register 0 always reads 0, and writes and busy_set to it are ignored
BYPASS, 1, 1 = a same-cycle write to the read address is forwarded to the read data

Ports:
clk  in  1  system clock; all state updates on its rising edge
rst_n  in  1  asynchronous active-low reset
rd_addr_a  in  ADDR_W  read port A address
rd_addr_b  in  ADDR_W  read port B address
rd_data_a  out  DATA_W  read port A data (combinational)
rd_data_b  out  DATA_W  read port B data (combinational)
we0  in  1  write enable, port 0 (high priority)
wr_addr0  in  ADDR_W  write address, port 0
wr_data0  in  DATA_W  write data, port 0
we1  in  1  write enable, port 1 (low priority)
wr_addr1  in  ADDR_W  write address, port 1
wr_data1  in  DATA_W  write data, port 1
busy_set  in  1  mark busy_addr as having a pending write
busy_addr  in  ADDR_W  register to mark busy
busy_a  out  1  scoreboard bit for rd_addr_a (combinational)
busy_b  out  1  scoreboard bit for rd_addr_b (combinational)
busy_vec  out  2**ADDR_W  full scoreboard, registered
wr_conflict  out  1  registered one-cycle pulse: both ports wrote the same address

Behaviour:
- Reset (rst_n low, asynchronous):
  - all registers cleared to 0
  - busy_vec cleared to 0
  - wr_conflict cleared to 0
  - reset overrides any write or busy_set in the same cycle.
- Storage updates on the rising edge of clk only, while rst_n is high.
- Write priority:
  - we0 and we1 at different addresses: both written in the same edge.
  - Same address: port 0 data wins and wr_conflict is 1 for the next cycle. Otherwise wr_conflict is 0.
  - A conflict on register 0 with ZERO_REG=1 does not pulse wr_conflict.
- ZERO_REG=1:
  - rd_data_x is 0 whenever rd_addr_x = 0, regardless of bypass.
  - Register 0 storage is never written, and busy_vec[0] stays 0.
- ZERO_REG=0: register 0 is an ordinary register.
- Read, BYPASS=0: rd_data_x = stored value. A write in the current cycle becomes visible the cycle after the edge.
- Read, BYPASS=1:
  - If we0 and wr_addr0 = rd_addr_x, then rd_data_x = wr_data0.
  - Else if we1 and wr_addr1 = rd_addr_x, then rd_data_x = wr_data1.
  - Else rd_data_x = stored value.
  - This is purely combinational: zero-latency forwarding, no extra state.
- Scoreboard, per register i, evaluated each edge:
  - Clear if (we0 and wr_addr0 = i) or (we1 and wr_addr1 = i).
  - Set if busy_set and busy_addr = i.
  - Set takes priority over clear in the same cycle, so a new pending write survives a completing older one.
  - Otherwise the bit holds.
- busy_a / busy_b:
  - Equal to busy_vec[rd_addr_x].
  - With BYPASS=1, forced to 0 when a write to that address is present this cycle; the value is forwarded, so no stall is needed.
  - With BYPASS=0, not forced.
- Port 0 and port 1 are symmetric for read and bypass except for the stated priority.
- Width rules:
  - Addresses are used unsigned and in full.
  - Depth is exactly 2**ADDR_W, so no out-of-range address exists.
  - No arithmetic is performed on data.

Test Plan:
1. Reset mid-operation: write 0xA5 to r3, set busy r5, assert rst_n low between edges -> r3 reads 0x00, busy_vec = 0 and wr_conflict = 0 immediately, without waiting for a clock edge.
2. Dual write, distinct addresses: we0 r2=0x11 and we1 r6=0x22 in one cycle, BYPASS=0 -> next cycle r2=0x11, r6=0x22, wr_conflict=0.
3. Same-address collision: we0 r4=0x33 and we1 r4=0x44 -> r4 reads 0x33 and wr_conflict=1 for exactly one cycle. Repeat on r0 with ZERO_REG=1 -> r0 reads 0 and wr_conflict stays 0.
4. Bypass: BYPASS=1, rd_addr_a=r1, we1 r1=0x5A in the same cycle -> rd_data_a=0x5A that cycle. With BYPASS=0 the old value is read that cycle and 0x5A the next.
5. Scoreboard:
   - busy_set r7 -> busy_vec[7]=1 next cycle and busy_a=1 with rd_addr_a=7.
   - Then we0 r7 together with busy_set r7 -> bit stays 1.
   - Then we0 r7 alone -> bit clears.
6. ZERO_REG=0 sweep: write 0xFF to every address including r0, then read each on both ports -> all read 0xFF. With ZERO_REG=1 -> r0 reads 0x00 and the others read 0xFF.
